sysid_boot_checker: RTL and testbench

Avalon-MM master that reads the system ID slave once after reset and on demand. It reads word 0 (system ID) and word 1 (build timestamp), compares both against build-time expected values, and reports the result. It sits directly in front of the sysid control slave. Its `done`/`match` outputs gate CPU reset release and drive a board status LED.

---
 rtl/sysid_boot_checker.sv | 185 ++++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_boot_checker.sv
// Reads the sysid slave (ID word, then build timestamp) after reset and on request,
// and reports whether both words equal the values this build expects.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1361531825,
    parameter int unsigned READ_LATENCY       = 1,
    parameter int unsigned START_DELAY        = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic        sysid_waitrequest,
    input  logic [31:0] sysid_readdata,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        timestamp_ok,
    output logic        match
);

    typedef enum logic [2:0] {
        DELAY,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        CHECK,
        IDLE
    } state_t;

    localparam logic [7:0] DELAY_END = 8'(START_DELAY);
    localparam bit         ZERO_LAT  = (READ_LATENCY == 0);
    localparam logic [1:0] LAT_LOAD  = ZERO_LAT ? 2'd0 : 2'(READ_LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  delay_cnt;
    logic [7:0]  delay_cnt_next;
    logic [1:0]  lat_cnt;
    logic [1:0]  lat_cnt_next;
    logic        read_next;
    logic        address_next;
    logic        busy_next;
    logic        done_next;
    logic        id_ok_next;
    logic        timestamp_ok_next;
    logic        match_next;
    logic [31:0] id_value_next;
    logic [31:0] timestamp_value_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= DELAY;
            delay_cnt       <= '0;
            lat_cnt         <= '0;
            sysid_read      <= 1'b0;
            sysid_address   <= 1'b0;
            id_value        <= '0;
            timestamp_value <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            id_ok           <= 1'b0;
            timestamp_ok    <= 1'b0;
            match           <= 1'b0;
        end else begin
            state           <= state_next;
            delay_cnt       <= delay_cnt_next;
            lat_cnt         <= lat_cnt_next;
            sysid_read      <= read_next;
            sysid_address   <= address_next;
            id_value        <= id_value_next;
            timestamp_value <= timestamp_value_next;
            busy            <= busy_next;
            done            <= done_next;
            id_ok           <= id_ok_next;
            timestamp_ok    <= timestamp_ok_next;
            match           <= match_next;
        end
    end

    // Every output is computed one cycle ahead here so the ports come straight off flops.
    always_comb begin
        state_next           = state;
        delay_cnt_next       = delay_cnt;
        lat_cnt_next         = lat_cnt;
        read_next            = sysid_read;
        address_next         = sysid_address;
        id_value_next        = id_value;
        timestamp_value_next = timestamp_value;
        busy_next            = busy;
        done_next            = done;
        id_ok_next           = id_ok;
        timestamp_ok_next    = timestamp_ok;
        match_next           = match;

        case (state)
            DELAY: begin
                // delay_cnt holds the number of cycles already spent since reset release
                if (delay_cnt == DELAY_END) begin
                    state_next   = RD_ID;
                    read_next    = 1'b1;
                    address_next = 1'b0;
                end else begin
                    delay_cnt_next = delay_cnt + 8'd1;
                end
            end

            RD_ID: begin
                if (!sysid_waitrequest) begin
                    if (ZERO_LAT) begin
                        id_value_next = sysid_readdata;
                        state_next    = RD_TS;
                        read_next     = 1'b1;
                        address_next  = 1'b1;
                    end else begin
                        state_next   = LAT_ID;
                        read_next    = 1'b0;
                        lat_cnt_next = LAT_LOAD;
                    end
                end
            end

            LAT_ID: begin
                if (lat_cnt == 2'd0) begin
                    id_value_next = sysid_readdata;
                    state_next    = RD_TS;
                    read_next     = 1'b1;
                    address_next  = 1'b1;
                end else begin
                    lat_cnt_next = lat_cnt - 2'd1;
                end
            end

            RD_TS: begin
                if (!sysid_waitrequest) begin
                    read_next = 1'b0;
                    if (ZERO_LAT) begin
                        timestamp_value_next = sysid_readdata;
                        state_next           = CHECK;
                    end else begin
                        state_next   = LAT_TS;
                        lat_cnt_next = LAT_LOAD;
                    end
                end
            end

            LAT_TS: begin
                if (lat_cnt == 2'd0) begin
                    timestamp_value_next = sysid_readdata;
                    state_next           = CHECK;
                end else begin
                    lat_cnt_next = lat_cnt - 2'd1;
                end
            end

            CHECK: begin
                id_ok_next        = (id_value == EXPECTED_ID);
                timestamp_ok_next = (timestamp_value == EXPECTED_TIMESTAMP);
                match_next        = (id_value == EXPECTED_ID) &&
                                    (timestamp_value == EXPECTED_TIMESTAMP);
                done_next         = 1'b1;
                busy_next         = 1'b0;
                state_next        = IDLE;
            end

            IDLE: begin
                if (start) begin
                    state_next   = RD_ID;
                    read_next    = 1'b1;
                    address_next = 1'b0;
                    busy_next    = 1'b1;
                end
            end

            default: begin
                state_next = DELAY;
            end
        endcase
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: three builds (latency 1, 0, 3) run side by side against
// simple sysid slave models, checked every cycle against a timeline model plus literals.
module tb_sysid_boot_checker;

    localparam int          NINST       = 3;
    localparam int          START_DELAY = 16;
    localparam logic [31:0] EXP_ID      = 32'd0;
    localparam logic [31:0] EXP_TS      = 32'd1361531825;
    localparam logic [31:0] BAD_TS      = 32'h1234_5678;
    localparam logic [31:0] NOISE       = 32'hDEAD_BEEF;
    localparam int          PH_DELAY    = 0;
    localparam int          PH_CHECK    = 1;
    localparam int          PH_IDLE     = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    logic start   = 1'b0;
    int   cyc     = -1;
    int   total   = 0;
    int   bad     = 0;

    logic        sysid_address     [NINST];
    logic        sysid_read        [NINST];
    logic        sysid_waitrequest [NINST];
    logic [31:0] sysid_readdata    [NINST];
    logic [31:0] id_value          [NINST];
    logic [31:0] timestamp_value   [NINST];
    logic        busy              [NINST];
    logic        done              [NINST];
    logic        id_ok             [NINST];
    logic        timestamp_ok      [NINST];
    logic        match             [NINST];

    logic [31:0] slave_id [NINST];
    logic [31:0] slave_ts [NINST];
    int          stall_id [NINST];
    int          stall_ts [NINST];

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= -1;
        else          cyc <= cyc + 1;
    end

    task automatic check_word(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b, want %b (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic goto_cycle(input int k);
        int guard;
        guard = 0;
        while (cyc < k && guard < 2000) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (cyc != k) begin
            total++;
            bad++;
            $display("[TB] FAIL timeline: at cycle %0d, wanted cycle %0d", cyc, k);
        end
    endtask

    task automatic apply_stimulus();
        #1 start = 1'b1;
        @(posedge clock);
        #2 start = 1'b0;
    endtask

    for (genvar g = 0; g < NINST; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        int          wait_id_seen;
        int          wait_ts_seen;
        int          pend;
        logic        pend_addr;
        int          m_edges;
        int          m_phase;
        int          m_rel;
        int          m_wid;
        int          m_wts;
        logic [31:0] m_new_id;
        logic [31:0] m_new_ts;
        logic [31:0] m_id;
        logic [31:0] m_ts;
        logic        m_done;
        logic        m_id_ok;
        logic        m_ts_ok;
        logic        m_match;

        sysid_boot_checker #(
            .EXPECTED_ID       (EXP_ID),
            .EXPECTED_TIMESTAMP(EXP_TS),
            .READ_LATENCY      (LAT),
            .START_DELAY       (START_DELAY)
        ) dut (
            .clock            (clock),
            .reset_n          (reset_n),
            .start            (start),
            .sysid_address    (sysid_address[g]),
            .sysid_read       (sysid_read[g]),
            .sysid_waitrequest(sysid_waitrequest[g]),
            .sysid_readdata   (sysid_readdata[g]),
            .id_value         (id_value[g]),
            .timestamp_value  (timestamp_value[g]),
            .busy             (busy[g]),
            .done             (done[g]),
            .id_ok            (id_ok[g]),
            .timestamp_ok     (timestamp_ok[g]),
            .match            (match[g])
        );

        // Slave: stalls the first N cycles of each read, then returns data LAT cycles later
        // (noise on every other cycle so a mistimed capture is visible).
        assign sysid_waitrequest[g] = sysid_read[g] &&
            (sysid_address[g] ? (wait_ts_seen < stall_ts[g]) : (wait_id_seen < stall_id[g]));

        assign sysid_readdata[g] = (LAT == 0)
            ? ((sysid_read[g] && !sysid_waitrequest[g])
                ? (sysid_address[g] ? slave_ts[g] : slave_id[g]) : NOISE)
            : ((pend == 1) ? (pend_addr ? slave_ts[g] : slave_id[g]) : NOISE);

        always @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                wait_id_seen <= 0;
                wait_ts_seen <= 0;
                pend         <= 0;
                pend_addr    <= 1'b0;
            end else begin
                if (sysid_read[g] && !sysid_address[g]) begin
                    if (sysid_waitrequest[g]) wait_id_seen <= wait_id_seen + 1;
                end else begin
                    wait_id_seen <= 0;
                end
                if (sysid_read[g] && sysid_address[g]) begin
                    if (sysid_waitrequest[g]) wait_ts_seen <= wait_ts_seen + 1;
                end else begin
                    wait_ts_seen <= 0;
                end
                if (LAT > 0 && sysid_read[g] && !sysid_waitrequest[g]) begin
                    pend      <= LAT;
                    pend_addr <= sysid_address[g];
                end else if (pend > 0) begin
                    pend <= pend - 1;
                end
            end
        end

        // Model: a check is a timeline measured from its first read cycle (m_rel = 0).
        always @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                m_edges  <= -1;
                m_phase  <= PH_DELAY;
                m_rel    <= 0;
                m_wid    <= 0;
                m_wts    <= 0;
                m_new_id <= '0;
                m_new_ts <= '0;
                m_id     <= '0;
                m_ts     <= '0;
                m_done   <= 1'b0;
                m_id_ok  <= 1'b0;
                m_ts_ok  <= 1'b0;
                m_match  <= 1'b0;
            end else begin
                m_edges <= m_edges + 1;
                if ((m_phase == PH_DELAY && m_edges + 1 == START_DELAY) ||
                    (m_phase == PH_IDLE && start)) begin
                    m_phase  <= PH_CHECK;
                    m_rel    <= 0;
                    m_wid    <= stall_id[g];
                    m_wts    <= stall_ts[g];
                    m_new_id <= slave_id[g];
                    m_new_ts <= slave_ts[g];
                end else if (m_phase == PH_CHECK) begin
                    m_rel <= m_rel + 1;
                    if (m_rel + 1 == m_wid + LAT + 1) m_id <= m_new_id;
                    if (m_rel + 1 == m_wid + m_wts + 2 * LAT + 2) m_ts <= m_new_ts;
                    if (m_rel + 1 == m_wid + m_wts + 2 * LAT + 3) begin
                        m_phase <= PH_IDLE;
                        m_done  <= 1'b1;
                        m_id_ok <= (m_new_id == EXP_ID);
                        m_ts_ok <= (m_new_ts == EXP_TS);
                        m_match <= (m_new_id == EXP_ID) && (m_new_ts == EXP_TS);
                    end
                end
            end
        end

        always @(negedge clock) begin : compare
            logic exp_read;
            int   ts_start;
            ts_start = m_wid + LAT + 1;
            exp_read = (m_phase == PH_CHECK) &&
                       ((m_rel <= m_wid) || (m_rel >= ts_start && m_rel <= ts_start + m_wts));
            check_bit($sformatf("i%0d_read", g), sysid_read[g], exp_read);
            if (exp_read || m_phase == PH_DELAY)
                check_bit($sformatf("i%0d_address", g), sysid_address[g], exp_read && m_rel >= ts_start);
            check_bit($sformatf("i%0d_busy", g), busy[g], m_phase != PH_IDLE);
            check_bit($sformatf("i%0d_done", g), done[g], m_done);
            check_bit($sformatf("i%0d_id_ok", g), id_ok[g], m_id_ok);
            check_bit($sformatf("i%0d_ts_ok", g), timestamp_ok[g], m_ts_ok);
            check_bit($sformatf("i%0d_match", g), match[g], m_match);
            check_word($sformatf("i%0d_id_value", g), id_value[g], m_id);
            check_word($sformatf("i%0d_ts_value", g), timestamp_value[g], m_ts);
        end
    end

    initial begin
        for (int i = 0; i < NINST; i++) begin
            slave_id[i] = EXP_ID;
            slave_ts[i] = EXP_TS;
            stall_id[i] = 0;
            stall_ts[i] = 0;
        end
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        $display("[TB] reset state");
        check_bit("lit_rst_busy", busy[0], 1'b1);
        check_bit("lit_rst_done", done[0], 1'b0);
        check_bit("lit_rst_read", sysid_read[0], 1'b0);
        check_word("lit_rst_ts", timestamp_value[0], 32'd0);
        @(negedge clock) reset_n = 1'b1;

        $display("[TB] boot check, matching slave");
        goto_cycle(15);
        check_bit("lit_read15", sysid_read[0], 1'b0);
        goto_cycle(16);
        check_bit("lit_read16", sysid_read[0], 1'b1);
        check_bit("lit_addr16", sysid_address[0], 1'b0);
        goto_cycle(17);
        check_bit("lit_read17", sysid_read[0], 1'b0);
        goto_cycle(18);
        check_bit("lit_read18", sysid_read[0], 1'b1);
        check_bit("lit_addr18", sysid_address[0], 1'b1);
        check_bit("lit_l0_done18", done[1], 1'b0);
        goto_cycle(19);
        check_bit("lit_l0_done19", done[1], 1'b1);
        goto_cycle(20);
        check_bit("lit_done20", done[0], 1'b0);
        goto_cycle(21);
        check_bit("lit_done21", done[0], 1'b1);
        check_bit("lit_match21", match[0], 1'b1);
        check_bit("lit_busy21", busy[0], 1'b0);
        check_word("lit_ts21", timestamp_value[0], 32'd1361531825);
        goto_cycle(24);
        check_bit("lit_l3_done24", done[2], 1'b0);
        goto_cycle(25);
        check_bit("lit_l3_done25", done[2], 1'b1);
        check_bit("lit_l3_match25", match[2], 1'b1);

        $display("[TB] timestamp mismatch");
        goto_cycle(26);
        for (int i = 0; i < NINST; i++) slave_ts[i] = BAD_TS;
        apply_stimulus();
        goto_cycle(27);
        check_bit("lit_restart_read27", sysid_read[0], 1'b1);
        goto_cycle(37);
        check_bit("lit_mm_id_ok", id_ok[0], 1'b1);
        check_bit("lit_mm_ts_ok", timestamp_ok[0], 1'b0);
        check_bit("lit_mm_match", match[0], 1'b0);
        check_word("lit_mm_ts", timestamp_value[0], 32'h1234_5678);
        check_word("lit_l3_mm_ts", timestamp_value[2], 32'h1234_5678);

        $display("[TB] waitrequest on the ID read");
        for (int i = 0; i < NINST; i++) begin
            slave_ts[i] = EXP_TS;
            stall_id[i] = 3;
        end
        apply_stimulus();
        goto_cycle(41);
        check_bit("lit_wait_read41", sysid_read[0], 1'b1);
        check_bit("lit_wait_addr41", sysid_address[0], 1'b0);
        goto_cycle(42);
        check_bit("lit_wait_read42", sysid_read[0], 1'b0);
        goto_cycle(43);
        check_bit("lit_l0_wait_match43", match[1], 1'b0);
        goto_cycle(44);
        check_bit("lit_l0_wait_match44", match[1], 1'b1);
        goto_cycle(45);
        check_bit("lit_wait_match45", match[0], 1'b0);
        goto_cycle(46);
        check_bit("lit_wait_match46", match[0], 1'b1);
        goto_cycle(51);
        check_bit("lit_l3_wait_match51", match[2], 1'b1);

        $display("[TB] re-check with changed ID");
        for (int i = 0; i < NINST; i++) begin
            stall_id[i] = 0;
            slave_id[i] = 32'd5;
        end
        apply_stimulus();
        goto_cycle(52);
        check_bit("lit_recheck_busy52", busy[0], 1'b1);
        check_bit("lit_recheck_match52", match[0], 1'b1);
        goto_cycle(53);
        apply_stimulus();
        goto_cycle(56);
        check_bit("lit_recheck_match56", match[0], 1'b1);
        goto_cycle(57);
        check_bit("lit_recheck_match57", match[0], 1'b0);
        check_bit("lit_recheck_id_ok57", id_ok[0], 1'b0);
        check_word("lit_recheck_id57", id_value[0], 32'd5);
        check_bit("lit_recheck_busy57", busy[0], 1'b0);
        goto_cycle(58);
        check_bit("lit_ignored_read58", sysid_read[0], 1'b0);
        check_bit("lit_ignored_busy58", busy[0], 1'b0);
        goto_cycle(62);
        check_word("lit_l3_recheck_id", id_value[2], 32'd5);
        check_bit("lit_l3_recheck_busy", busy[2], 1'b0);

        $display("[TB] reset in the middle of the timestamp read");
        for (int i = 0; i < NINST; i++) slave_id[i] = EXP_ID;
        apply_stimulus();
        goto_cycle(66);
        check_bit("lit_lat_ts_read66", sysid_read[0], 1'b0);
        check_bit("lit_lat_ts_busy66", busy[0], 1'b1);
        reset_n = 1'b0;
        #1;
        check_bit("lit_async_done", done[0], 1'b0);
        check_bit("lit_async_match", match[0], 1'b0);
        check_bit("lit_async_busy", busy[0], 1'b1);
        check_word("lit_async_ts", timestamp_value[0], 32'd0);
        check_word("lit_async_id", id_value[0], 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        goto_cycle(15);
        check_bit("lit_rb_read15", sysid_read[0], 1'b0);
        goto_cycle(16);
        check_bit("lit_rb_read16", sysid_read[0], 1'b1);
        goto_cycle(20);
        check_bit("lit_rb_done20", done[0], 1'b0);
        goto_cycle(21);
        check_bit("lit_rb_done21", done[0], 1'b1);
        check_bit("lit_rb_match21", match[0], 1'b1);
        goto_cycle(25);
        check_bit("lit_rb_l3_done25", done[2], 1'b1);
        goto_cycle(26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
